// File: rtl/inv_trans_reciprocal.sv
// inv_trans_reciprocal
// Reciprocal of a Q0.8 transmission value, returned as a Q2.6 operand
// saturated to 8 bits. One quotient bit is resolved per clock by a
// restoring divider. A sideband tag travels with each sample so that the
// downstream multiplier sees the pixel data aligned with its reciprocal.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | in_ready high, waiting for in_valid; divisor and tag latched here
// CALC  | one restoring-division step per clock, dividend bits MSB first
// DONE  | result held on out_inv/out_tag with out_valid until out_ready

module inv_trans_reciprocal #(
  parameter int T_MIN = 26,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_trans,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_inv,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // 1.0 in Q0.8 scaled by 2^6, so the 15-bit quotient is 1/t in Q2.6
  localparam logic [14:0] DIVIDEND = 15'd16384;
  localparam logic [7:0]  TMIN8    = 8'(T_MIN);
  localparam logic [3:0]  LAST_BIT = 4'd14;

  state_t             state_q;
  logic [7:0]         divisor_q;
  logic [TAG_W-1:0]   tag_q;
  // The true partial remainder is 9 bits wide (rem_shift); between steps
  // it is always below the divisor, so 8 bits are enough to store it.
  logic [7:0]         rem_q;
  logic [7:0]         rem_d;
  // Holds up to 14 resolved quotient bits; the 15th comes from quo_d on
  // the final step, so no bit is ever shifted out of the register.
  logic [13:0]        quo_q;
  logic [14:0]        quo_d;
  logic [3:0]         cnt_q;
  logic               out_valid_q;
  logic [7:0]         out_inv_q;
  logic [TAG_W-1:0]   out_tag_q;

  logic [8:0]         rem_shift;
  logic               q_bit;
  logic [7:0]         inv_d;
  logic [7:0]         divisor_d;

  // Clamp the incoming transmission so the divisor can never be tiny or zero
  always_comb begin
    divisor_d = in_trans;
    if (in_trans < TMIN8) begin
      divisor_d = TMIN8;
    end
  end

  // One restoring-division step plus saturation of the full quotient
  always_comb begin
    rem_shift = {rem_q, DIVIDEND[cnt_q]};
    q_bit     = 1'b0;
    rem_d     = rem_shift[7:0];
    if (rem_shift >= {1'b0, divisor_q}) begin
      q_bit = 1'b1;
      // Exact result is below the divisor, so 8-bit wraparound is harmless
      rem_d = rem_shift[7:0] - divisor_q;
    end
    quo_d = {quo_q, q_bit};
    inv_d = quo_d[7:0];
    if (|quo_d[14:8]) begin
      inv_d = 8'hFF;
    end
  end

  // Control FSM, divider datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      divisor_q   <= 8'd0;
      tag_q       <= '0;
      rem_q       <= 8'd0;
      quo_q       <= 14'd0;
      cnt_q       <= 4'd0;
      out_valid_q <= 1'b0;
      out_inv_q   <= 8'd0;
      out_tag_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            divisor_q <= divisor_d;
            tag_q     <= in_tag;
            rem_q     <= 8'd0;
            quo_q     <= 14'd0;
            cnt_q     <= LAST_BIT;
            state_q   <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d[13:0];
          if (cnt_q == 4'd0) begin
            out_inv_q   <= inv_d;
            out_tag_q   <= tag_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Ready is a pure decode of the state register, so it is high during reset
  always_comb begin
    in_ready = (state_q == IDLE);
  end

  assign out_valid = out_valid_q;
  assign out_inv   = out_inv_q;
  assign out_tag   = out_tag_q;

endmodule

// File: doc/inv_trans_reciprocal.md
Name: inv_trans_reciprocal

Overview:
- Produces the Q2.6 inverse-transmission operand consumed by the scene-recovery multiplier, which computes (Ic-Ac)*Inv_Trans.
- Takes a per-pixel transmission t (Q0.8, t = trans/256) and returns floor(1/t) in Q2.6, saturated to 8 bits.
- Uses an iterative restoring divider (one quotient bit per clock) with valid/ready handshakes on both sides.
- A sideband tag rides along with each sample, for example the pixel's Ic-Ac value, so the data reaches the multiplier aligned with its reciprocal.

Parameters:
- T_MIN, 26, lower clamp on trans (about 0.1 in Q0.8). Applied before division.
- TAG_W, 8, width of the sideband tag carried unchanged from input to output.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample; high only in IDLE
- in_trans  in  8  transmission, Q0.8
- in_tag  in  TAG_W  sideband data
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_inv  out  8  1/t, Q2.6, saturated
- out_tag  out  TAG_W  in_tag of the same sample

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0; out_inv=0; out_tag=0; iteration counter=0.
  - in_ready=1 as soon as state is IDLE, including while reset is held.
- Arithmetic:
  - d = max(in_trans, T_MIN), 8 bits.
  - Dividend N = 16384 (2^14, i.e. 1.0 in Q0.8 scaled by 2^6), 15 bits.
  - q = floor(N/d), 15 bits, computed MSB-first by restoring division: partial remainder 9 bits, one quotient bit per CALC cycle.
  - out_inv = 255 if |q[14:8], else q[7:0]. Truncation only, no rounding.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. On in_valid at a rising edge (edge 0):
    - latch d and in_tag;
    - clear remainder and quotient;
    - counter=14;
    - go to CALC.
  - CALC: in_ready=0. Each edge:
    - shift in the next dividend bit (MSB first);
    - subtract d if remainder>=d;
    - shift the quotient bit in;
    - decrement counter.
  - CALC exit: on the edge where counter==0 (edge 15), register out_inv (with saturation) and out_tag, set out_valid=1, go to DONE.
  - DONE: hold out_inv, out_tag and out_valid=1 stable until out_ready=1 at an edge. On that edge out_valid=0 and state goes to IDLE.
- Timing:
  - out_valid first high after edge 15, counting the accepting edge as edge 0.
  - Minimum sample period is 17 clocks (accept, 15 CALC edges, 1 DONE handshake edge) when out_ready is held high.
- No acceptance in DONE or CALC; in_valid is ignored there. The upstream must hold in_trans/in_tag until in_ready.
- out_ready while not in DONE: ignored.
- in_trans changing after acceptance: no effect (values were latched at edge 0).
- Reset asserted mid-CALC or in DONE:
  - the in-flight sample is discarded;
  - out_valid drops immediately (asynchronously);
  - no stale result appears after release.
- Divide-by-zero is impossible because T_MIN>=1. T_MIN=0 is an illegal configuration.

Test Plan:
- Reset mid-CALC: rst_n=0 for 2 cycles at edge 7. Required: out_valid=0 immediately, in_ready=1, and the next sample (trans=128) returns exactly 128.
- Nominal values, trans=128, then 255, then 200, with tag=0x5A each time. Required: out_inv=128 (2.0), 64 (64.25 floored), 81 (81.92 floored), respectively; out_tag=0x5A; out_valid rises after edge 15 each time.
- Saturation:
  - trans=64 (q=256) -> out_inv=255.
  - trans=65 -> 252.
  - trans=70 -> 234.
- Clamp: trans=0 and trans=10 are both treated as d=26 (q=630) -> out_inv=255.
- Backpressure: out_ready=0 for 20 cycles after out_valid. Required: out_inv/out_tag stable, in_ready=0 throughout, and a second in_valid pulse with trans=100 is not accepted. Raising out_ready gives one transfer, then IDLE, after which trans=100 is accepted -> 163.
- Back-to-back throughput: 10 samples with random trans>=T_MIN, in_valid and out_ready held high. Required: results match the floor/saturate model in order with tags preserved, spaced exactly 17 clocks apart.
